// File: rtl/usb_rx_pkg.sv
// usb_rx_pkg: packet/state enums and PID/CRC constants for the USB RX
// sequencer. Optional CRC16 check is enabled by USB_RX_CRC16_CHECK_EN.
package usb_rx_pkg;

   typedef enum logic [2:0] {
      RX_NONE  = 3'd0,
      RX_OUT   = 3'd1,
      RX_IN    = 3'd2,
      RX_DATA0 = 3'd3,
      RX_DATA1 = 3'd4,
      RX_ACK   = 3'd5,
      RX_NAK   = 3'd6,
      RX_STALL = 3'd7
   } rx_packet_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PID,
      ST_TOKEN,
      ST_DATA,
      ST_HSHAKE,
      ST_DONE,
      ST_ERR_WAIT
   } rx_state_t;

   localparam logic [3:0] PID_OUT   = 4'b0001;
   localparam logic [3:0] PID_IN    = 4'b1001;
   localparam logic [3:0] PID_DATA0 = 4'b0011;
   localparam logic [3:0] PID_DATA1 = 4'b1011;
   localparam logic [3:0] PID_ACK   = 4'b0010;
   localparam logic [3:0] PID_NAK   = 4'b1010;
   localparam logic [3:0] PID_STALL = 4'b1110;

   localparam logic [15:0] CRC16_POLY     = 16'h8005;
   localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
   localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

endpackage

// File: rtl/usb_rx_if.sv
// usb_rx_if: status inputs from decoder/shift register and FIFO, plus the
// packet/strobe/status outputs. master = datapath side, slave = usb_rx_ctrl.
interface usb_rx_if;
   import usb_rx_pkg::*;

   logic       sync_byte_detected;
   logic       byte_done;
   logic [7:0] rx_byte;
   logic       eop;
   logic       fifo_full;
   rx_packet_t rx_packet;
   logic       store_rx_data;
   logic [7:0] rx_packet_data;
   logic       rx_active;
   logic       rx_data_ready;
   logic       rx_error;

   modport master (
      output sync_byte_detected, byte_done, rx_byte, eop, fifo_full,
      input  rx_packet, store_rx_data, rx_packet_data,
      input  rx_active, rx_data_ready, rx_error
   );

   modport slave (
      input  sync_byte_detected, byte_done, rx_byte, eop, fifo_full,
      output rx_packet, store_rx_data, rx_packet_data,
      output rx_active, rx_data_ready, rx_error
   );

endinterface

// File: rtl/usb_crc16.sv
// usb_crc16: byte-serial USB CRC16 (LSB first). Ports: clk, n_rst, i_clr
// (reload init), i_en (absorb i_data), o_crc_nxt (value after this cycle).
module usb_crc16
   import usb_rx_pkg::*;
(
   input  logic        clk,
   input  logic        n_rst,
   input  logic        i_clr,
   input  logic        i_en,
   input  logic [7:0]  i_data,
   output logic [15:0] o_crc_nxt
);

   logic [15:0] r_crc;
   logic [15:0] w_upd;

   always_comb begin
      w_upd = r_crc;
      for (int i = 0; i < 8; i++) begin
         if (w_upd[15] ^ i_data[i])
            w_upd = {w_upd[14:0], 1'b0} ^ CRC16_POLY;
         else
            w_upd = {w_upd[14:0], 1'b0};
      end
      // lets the FSM judge the residual when eop and the last byte coincide
      o_crc_nxt = i_en ? w_upd : r_crc;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)     r_crc <= CRC16_INIT;
      else if (i_clr) r_crc <= CRC16_INIT;
      else if (i_en)  r_crc <= w_upd;
   end

endmodule

// File: rtl/usb_rx_ctrl.sv
// usb_rx_ctrl: USB RX packet sequencer (PID check, body, EOP, FIFO stores).
// Ports: clk, n_rst, bus (usb_rx_if.slave). Macro: USB_RX_CRC16_CHECK_EN.
module usb_rx_ctrl
   import usb_rx_pkg::*;
#(
   parameter int unsigned MAX_DATA_BYTES = 66,
   parameter int unsigned TOKEN_BYTES    = 2
) (
   input  logic     clk,
   input  logic     n_rst,
   usb_rx_if.slave  bus
);

   localparam logic [6:0] LP_MAX = 7'(MAX_DATA_BYTES);
   localparam logic [6:0] LP_TOK = 7'(TOKEN_BYTES);

   rx_state_t  r_state;
   logic [6:0] r_cnt;
   rx_packet_t r_packet;
   logic [7:0] r_data;
   logic       r_store;
   logic       r_active;
   logic       r_ready;
   logic       r_error;

   logic [6:0] w_cnt_inc;
   logic [6:0] w_cnt_nxt;
   logic       w_pid_ok;
   rx_packet_t w_pid_pkt;
   logic       w_sync;
   logic       w_take;
   logic       w_crc_ok;

   always_comb begin
      w_cnt_inc = (r_cnt == 7'h7F) ? r_cnt : r_cnt + 7'd1;
      w_cnt_nxt = bus.byte_done ? w_cnt_inc : r_cnt;
      w_pid_ok  = (bus.rx_byte[7:4] == ~bus.rx_byte[3:0]);
      w_pid_pkt = RX_NONE;
      case (bus.rx_byte[3:0])
         PID_OUT:   w_pid_pkt = RX_OUT;
         PID_IN:    w_pid_pkt = RX_IN;
         PID_DATA0: w_pid_pkt = RX_DATA0;
         PID_DATA1: w_pid_pkt = RX_DATA1;
         PID_ACK:   w_pid_pkt = RX_ACK;
         PID_NAK:   w_pid_pkt = RX_NAK;
         PID_STALL: w_pid_pkt = RX_STALL;
         default:   w_pid_pkt = RX_NONE;
      endcase
      w_sync = (r_state == ST_IDLE) && bus.sync_byte_detected;
      // a DATA byte is accepted only if the FIFO has room and length allows
      w_take = (r_state == ST_DATA) && bus.byte_done &&
               !bus.fifo_full && (w_cnt_inc <= LP_MAX);
   end

`ifdef USB_RX_CRC16_CHECK_EN
   logic [15:0] w_crc_nxt;

   usb_crc16 u_crc (
      .clk       (clk),
      .n_rst     (n_rst),
      .i_clr     (w_sync),
      .i_en      (w_take),
      .i_data    (bus.rx_byte),
      .o_crc_nxt (w_crc_nxt)
   );

   assign w_crc_ok = (w_crc_nxt == CRC16_RESIDUAL);
`else
   assign w_crc_ok = 1'b1;
`endif

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_packet <= RX_NONE;
         r_data   <= '0;
         r_store  <= 1'b0;
         r_active <= 1'b0;
         r_ready  <= 1'b0;
         r_error  <= 1'b0;
      end else begin
         r_store <= 1'b0;
         r_ready <= 1'b0;
         r_error <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_sync) begin
                  r_state  <= ST_PID;
                  r_active <= 1'b1;
                  r_cnt    <= '0;
                  r_packet <= RX_NONE;
               end
            end
            ST_PID: begin
               if (bus.byte_done && w_pid_ok &&
                   w_pid_pkt != RX_NONE && !bus.eop) begin
                  r_packet <= w_pid_pkt;
                  case (w_pid_pkt)
                     RX_OUT, RX_IN:     r_state <= ST_TOKEN;
                     RX_DATA0, RX_DATA1: r_state <= ST_DATA;
                     default:           r_state <= ST_HSHAKE;
                  endcase
               end else if (bus.byte_done || bus.eop) begin
                  r_state <= ST_ERR_WAIT;
                  r_error <= 1'b1;
               end
            end
            ST_TOKEN: begin
               if (bus.byte_done && w_cnt_inc > LP_TOK) begin
                  r_state <= ST_ERR_WAIT;
                  r_error <= 1'b1;
               end else begin
                  if (bus.byte_done) r_cnt <= w_cnt_inc;
                  if (bus.eop) begin
                     if (w_cnt_nxt == LP_TOK) begin
                        r_state <= ST_DONE;
                        r_ready <= 1'b1;
                     end else begin
                        r_state <= ST_ERR_WAIT;
                        r_error <= 1'b1;
                     end
                  end
               end
            end
            ST_DATA: begin
               if (bus.byte_done && !w_take) begin
                  r_state <= ST_ERR_WAIT;
                  r_error <= 1'b1;
               end else begin
                  if (w_take) begin
                     r_cnt   <= w_cnt_inc;
                     r_data  <= bus.rx_byte;
                     r_store <= 1'b1;
                  end
                  if (bus.eop) begin
                     if (w_cnt_nxt >= 7'd2 && w_crc_ok) begin
                        r_state <= ST_DONE;
                        r_ready <= 1'b1;
                     end else begin
                        r_state <= ST_ERR_WAIT;
                        r_error <= 1'b1;
                     end
                  end
               end
            end
            ST_HSHAKE: begin
               if (bus.byte_done) begin
                  r_state <= ST_ERR_WAIT;
                  r_error <= 1'b1;
               end else if (bus.eop) begin
                  r_state <= ST_DONE;
                  r_ready <= 1'b1;
               end
            end
            ST_DONE: begin
               r_state  <= ST_IDLE;
               r_active <= 1'b0;
            end
            ST_ERR_WAIT: begin
               if (bus.eop) begin
                  r_state  <= ST_IDLE;
                  r_active <= 1'b0;
               end
            end
            default: begin
               r_state  <= ST_IDLE;
               r_active <= 1'b0;
            end
         endcase
      end
   end

   assign bus.rx_packet      = r_packet;
   assign bus.store_rx_data  = r_store;
   assign bus.rx_packet_data = r_data;
   assign bus.rx_active      = r_active;
   assign bus.rx_data_ready  = r_ready;
   assign bus.rx_error       = r_error;

endmodule

// File: tb/tb_usb_rx_ctrl.sv
// tb_usb_rx_ctrl: directed + random packets for usb_rx_ctrl, checked
// against a packet-level reference model of the receive rules.
module tb_usb_rx_ctrl;
   import usb_rx_pkg::*;

`ifdef USB_RX_CRC16_CHECK_EN
   localparam bit CRC_EN = 1'b1;
`else
   localparam bit CRC_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic n_rst;
   int   checks = 0;
   int   errors = 0;

   usb_rx_if bus ();

   usb_rx_ctrl dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [7:0] mon_data[$];
   int         mon_ready;
   int         mon_err;
   int         mon_lat_bad;
   logic       prev_bd = 1'b0;

   always @(negedge clk) begin
      if (bus.store_rx_data === 1'b1) begin
         mon_data.push_back(bus.rx_packet_data);
         if (prev_bd !== 1'b1) mon_lat_bad++;
      end
      if (bus.rx_data_ready === 1'b1) mon_ready++;
      if (bus.rx_error === 1'b1) mon_err++;
      prev_bd = bus.byte_done;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] crc_run(input logic [7:0] q[$]);
      logic [15:0] c;
      logic        fb;
      c = 16'hFFFF;
      foreach (q[i]) begin
         for (int b = 0; b < 8; b++) begin
            fb = c[15] ^ q[i][b];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
         end
      end
      return c;
   endfunction

   // appends the inverted remainder, high register bit transmitted first
   task automatic add_crc(inout logic [7:0] q[$]);
      logic [15:0] c;
      logic [7:0]  b0, b1;
      c = ~crc_run(q);
      for (int i = 0; i < 8; i++) begin
         b0[i] = c[15 - i];
         b1[i] = c[7 - i];
      end
      q.push_back(b0);
      q.push_back(b1);
   endtask

   // reference: outcome of a packet from the receive rules
   task automatic predict(input logic [7:0] pid, input logic [7:0] body[$],
                          input int full_at, output bit ok,
                          output logic [7:0] st[$], output int pkt,
                          output bit known);
      int kind;
      st    = {};
      ok    = 1'b0;
      pkt   = 0;
      kind  = 0;
      known = (pid[7:4] == ~pid[3:0]);
      if (known) begin
         case (pid[3:0])
            4'b0001: begin pkt = 1; kind = 1; end
            4'b1001: begin pkt = 2; kind = 1; end
            4'b0011: begin pkt = 3; kind = 2; end
            4'b1011: begin pkt = 4; kind = 2; end
            4'b0010: begin pkt = 5; kind = 3; end
            4'b1010: begin pkt = 6; kind = 3; end
            4'b1110: begin pkt = 7; kind = 3; end
            default: known = 1'b0;
         endcase
      end
      if (!known) return;
      if (kind == 1) ok = (body.size() == 2);
      if (kind == 3) ok = (body.size() == 0);
      if (kind == 2) begin
         for (int i = 0; i < body.size(); i++) begin
            if (i == full_at || i >= 66) return;
            st.push_back(body[i]);
         end
         ok = (body.size() >= 2) &&
              (!CRC_EN || crc_run(body) == 16'h800D);
      end
   endtask

   task automatic put_byte(input logic [7:0] b, input logic full);
      bus.rx_byte   = b;
      bus.byte_done = 1'b1;
      bus.fifo_full = full;
      tick();
      bus.byte_done = 1'b0;
      bus.fifo_full = 1'b0;
      bus.rx_byte   = 8'($urandom);
      repeat ($urandom_range(3, 1)) tick();
   endtask

   task automatic send_pkt(input string tag, input logic [7:0] pid,
                           input logic [7:0] body[$], input int full_at);
      bit         ok, known;
      int         pkt;
      logic [7:0] st[$];
      int         n;
      predict(pid, body, full_at, ok, st, pkt, known);
      mon_data.delete();
      mon_ready   = 0;
      mon_err     = 0;
      mon_lat_bad = 0;
      bus.sync_byte_detected = 1'b1;
      tick();
      bus.sync_byte_detected = 1'b0;
      chk({tag, "_active"}, 32'(bus.rx_active), 32'd1);
      tick();
      put_byte(pid, 1'b0);
      foreach (body[i]) put_byte(body[i], i == full_at);
      bus.eop = 1'b1;
      tick();
      tick();
      bus.eop = 1'b0;
      n = 0;
      while (bus.rx_active === 1'b1 && n < 30) begin
         tick();
         n++;
      end
      chk({tag, "_idle_timeout"}, 32'(n < 30), 32'd1);
      tick();
      tick();
      chk({tag, "_ready"}, 32'(mon_ready), 32'(ok));
      chk({tag, "_error"}, 32'(mon_err), 32'(!ok));
      chk({tag, "_nstore"}, 32'(mon_data.size()), 32'(st.size()));
      chk({tag, "_latency"}, 32'(mon_lat_bad), 32'd0);
      foreach (st[i])
         if (i < mon_data.size())
            chk({tag, "_data"}, 32'(mon_data[i]), 32'(st[i]));
      if (known)
         chk({tag, "_pkt"}, 32'(bus.rx_packet), 32'(pkt));
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_pkt"}, 32'(bus.rx_packet), 32'(RX_NONE));
      chk({tag, "_data"}, 32'(bus.rx_packet_data), 32'd0);
      chk({tag, "_store"}, 32'(bus.store_rx_data), 32'd0);
      chk({tag, "_active"}, 32'(bus.rx_active), 32'd0);
      chk({tag, "_ready"}, 32'(bus.rx_data_ready), 32'd0);
      chk({tag, "_error"}, 32'(bus.rx_error), 32'd0);
   endtask

   initial begin
      logic [7:0] q[$];
      logic [7:0] pid;
      int         k, fa;
      n_rst                  = 1'b0;
      bus.sync_byte_detected = 1'b0;
      bus.byte_done          = 1'b0;
      bus.rx_byte            = 8'h00;
      bus.eop                = 1'b0;
      bus.fifo_full          = 1'b0;
      #12;
      chk_reset_outs("rst");
      tick();
      n_rst = 1'b1;
      repeat (2) tick();

      q = {8'h11, 8'h22, 8'hAA, 8'hBB};
      send_pkt("data0", 8'hC3, q, -1);
      q = {8'($urandom), 8'($urandom)};
      send_pkt("out", 8'hE1, q, -1);
      q = {};
      send_pkt("ack", 8'hD2, q, -1);
      q = {8'h55};
      send_pkt("ack_extra", 8'hD2, q, -1);
      q = {};
      send_pkt("bad_pid", 8'hC4, q, -1);
      send_pkt("ack_after", 8'hD2, q, -1);
      q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      send_pkt("data1_full", 8'h4B, q, 2);
      q = {};
      for (int i = 0; i < 67; i++) q.push_back(8'($urandom));
      send_pkt("too_long", 8'hC3, q, -1);
      q = {8'h01};
      add_crc(q);
      send_pkt("crc_good", 8'hC3, q, -1);
      q[1] = q[1] ^ 8'h04;
      send_pkt("crc_flip", 8'hC3, q, -1);
      q = {};
      add_crc(q);
      send_pkt("zero_len", 8'h4B, q, -1);

      for (int r = 0; r < 24; r++) begin
         q  = {};
         fa = -1;
         k  = int'($urandom_range(3, 0));
         case (k)
            0: begin
               pid = ($urandom_range(1, 0) != 0) ? 8'hC3 : 8'h4B;
               for (int i = 0; i < int'($urandom_range(8, 0)); i++)
                  q.push_back(8'($urandom));
               add_crc(q);
               if ($urandom_range(3, 0) == 0)
                  fa = int'($urandom_range(q.size() - 1, 0));
            end
            1: begin
               pid = ($urandom_range(1, 0) != 0) ? 8'hE1 : 8'h69;
               for (int i = 0; i < int'($urandom_range(3, 1)); i++)
                  q.push_back(8'($urandom));
            end
            2: begin
               case ($urandom_range(2, 0))
                  0: pid = 8'hD2;
                  1: pid = 8'h5A;
                  default: pid = 8'h1E;
               endcase
               if ($urandom_range(2, 0) == 0) q.push_back(8'($urandom));
            end
            default: begin
               pid = 8'($urandom);
               for (int i = 0; i < int'($urandom_range(3, 0)); i++)
                  q.push_back(8'($urandom));
            end
         endcase
         send_pkt("rand", pid, q, fa);
      end

      // asynchronous reset while a DATA store strobe is high
      bus.sync_byte_detected = 1'b1;
      tick();
      bus.sync_byte_detected = 1'b0;
      tick();
      put_byte(8'hC3, 1'b0);
      bus.rx_byte   = 8'h5A;
      bus.byte_done = 1'b1;
      tick();
      bus.byte_done = 1'b0;
      chk("pre_rst_store", 32'(bus.store_rx_data), 32'd1);
      #1;
      n_rst = 1'b0;
      #1;
      chk_reset_outs("mid_rst");
      tick();
      n_rst = 1'b1;
      repeat (2) tick();
      q = {};
      send_pkt("ack_post_rst", 8'hD2, q, -1);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
